// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bundle: hazard sources from the datapath, the data-memory
// handshake, and the latch enables/flushes plus status driven back.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic             use_rs1_ID;
  logic             use_rs2_ID;
  logic [4:0]       rd_EXE;
  logic             MemRead_EXE;
  logic             branch_taken_EXE;
  logic             mem_req_MEM;
  logic             mem_ack;
  logic             mem_stb;
  logic             en_PC;
  logic             en_IFID;
  logic             flush_IFID;
  logic             en_IDEX;
  logic             flush_IDEX;
  logic             en_EXMEM;
  logic             en_MEMWB;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Datapath / memory side
  modport master (
    output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EXE, MemRead_EXE,
           branch_taken_EXE, mem_req_MEM, mem_ack,
    input  mem_stb, en_PC, en_IFID, flush_IFID, en_IDEX, flush_IDEX,
           en_EXMEM, en_MEMWB, mem_err, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EXE, MemRead_EXE,
           branch_taken_EXE, mem_req_MEM, mem_ack,
    output mem_stb, en_PC, en_IFID, flush_IFID, en_IDEX, flush_IDEX,
           en_EXMEM, en_MEMWB, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-latch enables/flushes from load-use, taken-branch and
// memory wait-state sources, with a memory timeout watchdog and perf counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hif
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t           state;
  logic [7:0]       wcnt;
  logic             err_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic memstall, lu, live;
  logic en_pc, en_ifid, fl_ifid, en_idex, fl_idex, en_exmem, en_memwb;

  assign live     = (state != ERR);
  assign memstall = live & hif.mem_req_MEM & ~hif.mem_ack;
  assign lu       = hif.MemRead_EXE & (hif.rd_EXE != 5'd0) &
                    ((hif.use_rs1_ID & (hif.rs1_ID == hif.rd_EXE)) |
                     (hif.use_rs2_ID & (hif.rs2_ID == hif.rd_EXE)));

  // Reset gating keeps every latch frozen while rst is high, independent of state.
  always_comb begin
    en_pc    = 1'b0;
    en_ifid  = 1'b0;
    fl_ifid  = 1'b0;
    en_idex  = 1'b0;
    fl_idex  = 1'b0;
    en_exmem = 1'b0;
    en_memwb = 1'b0;
    if (!rst && live && !memstall) begin
      en_idex  = 1'b1;
      en_exmem = 1'b1;
      en_memwb = 1'b1;
      if (hif.branch_taken_EXE) begin
        en_pc   = 1'b1;
        en_ifid = 1'b1;
        fl_ifid = 1'b1;
        fl_idex = 1'b1;
      end else if (lu) begin
        fl_idex = 1'b1;
      end else begin
        en_pc   = 1'b1;
        en_ifid = 1'b1;
      end
    end
  end

  assign hif.mem_stb    = ~rst & live & hif.mem_req_MEM;
  assign hif.en_PC      = en_pc;
  assign hif.en_IFID    = en_ifid;
  assign hif.flush_IFID = fl_ifid;
  assign hif.en_IDEX    = en_idex;
  assign hif.flush_IDEX = fl_idex;
  assign hif.en_EXMEM   = en_exmem;
  assign hif.en_MEMWB   = en_memwb;
  assign hif.mem_err    = err_q;
  assign hif.stall_cnt  = stall_q;
  assign hif.flush_cnt  = flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wcnt  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      case (state)
        RUN: if (memstall) begin
          state <= MEM_WAIT;
          wcnt  <= 8'd1;
        end
        // An ack on the timeout cycle still wins because memstall is then low.
        MEM_WAIT: if (!memstall) begin
          state <= RUN;
          wcnt  <= 8'd0;
        end else if (wcnt == 8'(MEM_TIMEOUT)) begin
          state <= ERR;
          err_q <= 1'b1;
        end else begin
          wcnt <= wcnt + 8'd1;
        end
        default: state <= ERR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (live && !en_pc && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (fl_ifid && flush_q != '1)        flush_q <= flush_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench: the driver queues the expected control word per cycle,
// a negedge monitor pops and compares it against the controller outputs.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 3;
  localparam int TMO   = 4;

  // {en_PC,en_IFID,flush_IFID,en_IDEX,flush_IDEX,en_EXMEM,en_MEMWB}
  localparam logic [6:0] NORM = 7'b1101011;
  localparam logic [6:0] BR   = 7'b1111111;
  localparam logic [6:0] LU   = 7'b0001111;
  localparam logic [6:0] FRZ  = 7'b0000000;

  typedef struct {
    string            name;
    logic [6:0]       ctrl;
    logic             stb;
    logic             err;
    logic             chk;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();
  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hif(hif.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc(input string name, input logic rv, input logic mid_rst,
                     input logic [4:0] rs1, input logic u1, input logic [4:0] rd,
                     input logic mr, input logic br, input logic req, input logic ack,
                     input logic [6:0] ctrl, input logic stb, input logic err,
                     input logic chk, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rv;
    hif.rs1_ID = rs1;       hif.use_rs1_ID = u1;
    hif.rs2_ID = 5'd31;     hif.use_rs2_ID = 1'b0;
    hif.rd_EXE = rd;        hif.MemRead_EXE = mr;
    hif.branch_taken_EXE = br;
    hif.mem_req_MEM = req;  hif.mem_ack = ack;
    e.name = name; e.ctrl = ctrl; e.stb = stb; e.err = err;
    e.chk = chk; e.scnt = CNT_W'(sc); e.fcnt = CNT_W'(fc);
    sb.push_back(e);
    if (mid_rst) begin
      #2;
      rst = 1'b1;
    end
  endtask

  task automatic idle(input string name, input logic [6:0] ctrl, input logic err,
                      input logic chk, input int sc, input int fc);
    cyc(name, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
        ctrl, 1'b0, err, chk, sc, fc);
  endtask

  task automatic rst_pulse(input string name);
    cyc(name, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
        FRZ, 1'b0, 1'b0, 1'b1, 0, 0);
  endtask

  // Monitor: every cycle presents a control word; compare against the queue head.
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {hif.en_PC, hif.en_IFID, hif.flush_IFID, hif.en_IDEX,
               hif.flush_IDEX, hif.en_EXMEM, hif.en_MEMWB};
        total++;
        if (act !== e.ctrl || hif.mem_stb !== e.stb || hif.mem_err !== e.err) begin
          bad++;
          $display("FAIL %s: ctrl=%b stb=%b err=%b expected ctrl=%b stb=%b err=%b",
                   e.name, act, hif.mem_stb, hif.mem_err, e.ctrl, e.stb, e.err);
        end
        if (e.chk) begin
          total++;
          if (hif.stall_cnt !== e.scnt || hif.flush_cnt !== e.fcnt) begin
            bad++;
            $display("FAIL %s_cnt: stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     e.name, hif.stall_cnt, hif.flush_cnt, e.scnt, e.fcnt);
          end
        end
      end
    end
  end

  initial begin
    int n;
    hif.rs1_ID = 5'd0; hif.rs2_ID = 5'd0; hif.use_rs1_ID = 1'b0; hif.use_rs2_ID = 1'b0;
    hif.rd_EXE = 5'd0; hif.MemRead_EXE = 1'b0; hif.branch_taken_EXE = 1'b0;
    hif.mem_req_MEM = 1'b1; hif.mem_ack = 1'b0;

    rst_pulse("reset");
    // load-use inserts exactly one bubble
    cyc("lu", 0, 0, 5'd5, 1, 5'd5, 1, 0, 0, 0, LU, 0, 0, 1, 0, 0);
    idle("lu_after", NORM, 0, 1, 1, 0);
    cyc("rd_zero", 0, 0, 5'd0, 1, 5'd0, 1, 0, 0, 0, NORM, 0, 0, 1, 1, 0);
    cyc("lu_unused", 0, 0, 5'd7, 0, 5'd7, 1, 0, 0, 0, NORM, 0, 0, 1, 1, 0);

    // branch squashes a same-cycle load-use
    rst_pulse("reset2");
    cyc("br_lu", 0, 0, 5'd5, 1, 5'd5, 1, 1, 0, 0, BR, 0, 0, 1, 0, 0);
    idle("br_after", NORM, 0, 1, 0, 1);

    // memory wait of 3 cycles with a branch held across the stall
    rst_pulse("reset3");
    for (int i = 0; i < 3; i++)
      cyc("mem_wait", 0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 0, FRZ, 1, 0, 1, i, 0);
    cyc("mem_ack", 0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 1, BR, 1, 0, 1, 3, 0);
    idle("mem_after", NORM, 0, 1, 3, 1);
    cyc("ack_noreq", 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1, NORM, 0, 0, 1, 3, 1);

    // ack on the timeout cycle wins
    rst_pulse("reset4");
    for (int i = 0; i < TMO; i++)
      cyc("tmo_edge_wait", 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 1, 0, 1, i, 0);
    cyc("tmo_edge_ack", 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, NORM, 1, 0, 1, 4, 0);
    idle("tmo_edge_after", NORM, 0, 1, 4, 0);

    // timeout: 1 RUN + TMO MEM_WAIT stall cycles, then sticky ERR
    rst_pulse("reset5");
    for (int i = 0; i <= TMO; i++)
      cyc("tmo_wait", 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 1, 0, 1, i, 0);
    cyc("err", 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 0, 1, 1, 5, 0);
    cyc("err_ack", 0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 1, FRZ, 0, 1, 1, 5, 0);
    idle("err_hold", FRZ, 1, 1, 5, 0);
    rst_pulse("err_reset");
    idle("err_cleared", NORM, 0, 1, 0, 0);

    // reset asserted mid-wait, between clock edges
    cyc("mw1", 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 1, 0, 1, 0, 0);
    cyc("mw2", 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 1, 0, 1, 1, 0);
    cyc("mid_rst", 0, 1, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 0, 0, 1, 0, 0);
    idle("mid_rst_after", NORM, 0, 1, 0, 0);

    // saturation of both 3-bit counters
    for (int i = 0; i < 9; i++)
      cyc("sat_lu", 0, 0, 5'd9, 1, 5'd9, 1, 0, 0, 0, LU, 0, 0, 0, 0, 0);
    idle("sat_stall", NORM, 0, 1, 7, 0);
    for (int i = 0; i < 9; i++)
      cyc("sat_br", 0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, BR, 0, 0, 0, 0, 0);
    idle("sat_flush", NORM, 0, 1, 7, 7);

    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Generates per-stage enables and flushes from three sources: load-use hazards, taken branches/jumps, and data-memory wait states.
- Contains a memory-handshake FSM with a timeout watchdog and saturating stall/flush performance counters.
- Sits beside the datapath; its outputs drive the EN/flush inputs of every pipeline latch.

Parameters:
- MEM_TIMEOUT, 15, max MEM_WAIT cycles before entering ERR (range 1..255).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_ID  in  5  source register 1 of the ID-stage instruction.
- rs2_ID  in  5  source register 2 of the ID-stage instruction.
- use_rs1_ID  in  1  ID instruction reads rs1.
- use_rs2_ID  in  1  ID instruction reads rs2.
- rd_EXE  in  5  destination register of the EX-stage instruction.
- MemRead_EXE  in  1  EX-stage instruction is a load.
- branch_taken_EXE  in  1  EX resolved a taken branch or jump.
- mem_req_MEM  in  1  MEM-stage instruction accesses data memory.
- mem_ack  in  1  data memory completes the access this cycle.
- mem_stb  out  1  request strobe to data memory.
- en_PC  out  1  PC register enable.
- en_IFID  out  1  IF/ID latch enable.
- flush_IFID  out  1  IF/ID latch loads a NOP.
- en_IDEX  out  1  ID/EX latch enable.
- flush_IDEX  out  1  ID/EX latch loads a bubble.
- en_EXMEM  out  1  EX/MEM latch enable.
- en_MEMWB  out  1  MEM/WB latch enable.
- mem_err  out  1  sticky timeout error.
- stall_cnt  out  CNT_W  cycles with en_PC=0 while not in ERR (saturating).
- flush_cnt  out  CNT_W  cycles with flush_IFID=1 (saturating).

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Internal wait counter wcnt is 8 bits.
- Reset (asynchronous):
  - state=RUN, wcnt=0, counters=0, mem_err=0.
  - While rst=1, all en_*, flush_* and mem_stb are forced to 0.
- Definitions:
  - memstall = mem_req_MEM & !mem_ack, evaluated in RUN or MEM_WAIT.
  - lu = MemRead_EXE & (rd_EXE != 0) & ((use_rs1_ID & rs1_ID == rd_EXE) | (use_rs2_ID & rs2_ID == rd_EXE)).
- mem_stb = mem_req_MEM in RUN and MEM_WAIT; 0 in ERR.
- Output priority, combinational from state and inputs. Latches see the result at the next clock edge.
  1. ERR: all en_* = 0, flush_* = 0.
  2. memstall: all en_* = 0, flush_* = 0. The whole pipe freezes; a pending branch or hazard is held and re-evaluated when the stall releases.
  3. branch_taken_EXE: all en_* = 1, flush_IFID = 1, flush_IDEX = 1. A load-use hazard in the same cycle is ignored because its instruction is squashed.
  4. lu: en_PC = 0, en_IFID = 0, en_IDEX = 1 with flush_IDEX = 1, en_EXMEM = 1, en_MEMWB = 1. This inserts exactly one bubble.
  5. Otherwise: all en_* = 1, flush_* = 0.
- Transitions:
  - RUN -> MEM_WAIT when memstall; wcnt <= 1.
  - MEM_WAIT, mem_ack = 1 -> RUN. Enables follow priorities 3–5 in that same cycle; zero added latency after ack.
  - MEM_WAIT, mem_ack = 0, wcnt == MEM_TIMEOUT -> ERR, mem_err <= 1. Otherwise wcnt <= wcnt + 1.
  - mem_ack arriving in the same cycle the timeout is reached wins: go to RUN, no error.
  - ERR holds until rst; mem_ack is ignored.
- mem_ack while mem_req_MEM = 0 is ignored.
- Counters:
  - stall_cnt increments in any non-ERR cycle with en_PC = 0.
  - flush_cnt increments on flush_IFID = 1.
  - Both saturate at all-ones and do not wrap.
- Reset asserted mid-wait aborts the wait immediately; mem_stb drops asynchronously.

Test Plan:
- Load-use: MemRead_EXE=1, rd_EXE=5, rs1_ID=5, use_rs1_ID=1, single cycle -> en_PC=0, en_IFID=0, flush_IDEX=1 for exactly 1 cycle; stall_cnt=1.
- rd_EXE=0 with rs1_ID=0, MemRead_EXE=1 -> no stall, all en=1.
- branch_taken_EXE=1 together with the load-use case above -> flush_IFID=flush_IDEX=1, en_PC=1; flush_cnt=1, stall_cnt=0.
- mem_req_MEM=1, mem_ack after 3 cycles -> all en=0 for 3 cycles, state back to RUN on the ack cycle with en=1; stall_cnt=3.
- mem_req_MEM=1, no ack, MEM_TIMEOUT=4 -> after 5 stall cycles (1 RUN + 4 MEM_WAIT) mem_err=1, mem_stb=0; state stays ERR until rst pulse, then RUN with mem_err=0.
- Assert rst during MEM_WAIT -> outputs go to 0 without waiting for a clock edge; counters read 0 after release.
